// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared encodings for the decode/control stage: opcodes, immediate kinds,
// register-write and branch codes, ALU codes and the control bundle layout.
package decode_ctrl_pipe_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] ITYPE    = 3'd1;
    localparam logic [2:0] STYPE    = 3'd2;
    localparam logic [2:0] BTYPE    = 3'd3;
    localparam logic [2:0] UTYPE    = 3'd4;
    localparam logic [2:0] JTYPE    = 3'd5;

    // Load codes are funct3+1, so LBU/LHU land on 5/6.
    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] RW_LB      = 3'd1;
    localparam logic [2:0] RW_LH      = 3'd2;
    localparam logic [2:0] RW_LW      = 3'd3;
    localparam logic [2:0] RW_LBU     = 3'd5;
    localparam logic [2:0] RW_LHU     = 3'd6;

    localparam logic [2:0] NOBRANCH = 3'd0;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SLL  = 5'd1;
    localparam logic [4:0] ALU_SLT  = 5'd2;
    localparam logic [4:0] ALU_SLTU = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_AND  = 5'd7;
    localparam logic [4:0] ALU_SUB  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd13;
    localparam logic [4:0] ALU_LUI  = 5'd16;

    localparam logic [2:0] MD_DIV = 3'b100;
    localparam logic [2:0] MD_REM = 3'b110;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       jal;
        logic       jalr;
        logic       load_npc;
        logic       mem_to_reg;
        logic       alu_src1;
        logic [2:0] reg_write;
        logic [3:0] mem_write;
        logic [1:0] reg_read;
        logic [2:0] branch_type;
        logic [4:0] alu_type;
        logic [1:0] alu_src2;
        logic [2:0] imm_type;
        logic       md_en;
        logic [2:0] md_op;
        logic       illegal;
    } ctrl_t;

    // DIV, DIVU, REM, REMU all have funct3[2] set; the MUL family does not.
    function automatic logic md_is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/decode_ctrl_pipe_comb.sv
// Purely combinational RV32I(+M) decode of one instruction word into the
// control bundle, including illegal-op detection.
module decode_ctrl_pipe_comb
    import decode_ctrl_pipe_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        ctrl           = '0;
        ctrl.rd        = instr[11:7];
        ctrl.rs1       = instr[19:15];
        ctrl.rs2       = instr[24:20];
        ctrl.reg_write = RW_LW;
        ctrl.alu_type  = ALU_ADD;
        case (opcode)
            OP_LUI: begin
                ctrl.imm_type = UTYPE;
                ctrl.alu_src2 = 2'b10;
                ctrl.alu_type = ALU_LUI;
            end
            OP_AUIPC: begin
                ctrl.imm_type = UTYPE;
                ctrl.alu_src1 = 1'b1;
                ctrl.alu_src2 = 2'b10;
            end
            OP_JAL: begin
                ctrl.jal      = 1'b1;
                ctrl.load_npc = 1'b1;
                ctrl.imm_type = JTYPE;
            end
            OP_JALR: begin
                ctrl.jalr     = 1'b1;
                ctrl.load_npc = 1'b1;
                ctrl.imm_type = ITYPE;
                ctrl.alu_src2 = 2'b10;
                ctrl.reg_read = 2'b10;
            end
            OP_BRANCH: begin
                ctrl.reg_write   = NOREGWRITE;
                ctrl.imm_type    = BTYPE;
                ctrl.reg_read    = 2'b11;
                ctrl.branch_type = funct3 - 3'd2;
                ctrl.illegal     = (funct3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                ctrl.reg_write  = funct3 + 3'd1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.imm_type   = ITYPE;
                ctrl.alu_src2   = 2'b10;
                ctrl.reg_read   = 2'b10;
                ctrl.illegal    = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OP_STORE: begin
                ctrl.reg_write = NOREGWRITE;
                ctrl.imm_type  = STYPE;
                ctrl.alu_src2  = 2'b10;
                ctrl.reg_read  = 2'b11;
                case (funct3)
                    3'd0:    ctrl.mem_write = 4'b0001;
                    3'd1:    ctrl.mem_write = 4'b0011;
                    3'd2:    ctrl.mem_write = 4'b1111;
                    default: ctrl.illegal   = 1'b1;
                endcase
            end
            OP_IMM: begin
                ctrl.imm_type = ITYPE;
                ctrl.reg_read = 2'b10;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    ctrl.alu_src2 = 2'b01;
                    ctrl.alu_type = {2'b00, funct3} + ((funct3 == 3'b101 && funct7 == F7_ALT) ? 5'd8 : 5'd0);
                end else begin
                    ctrl.alu_src2 = 2'b10;
                    ctrl.alu_type = {2'b00, funct3};
                end
            end
            OP_REG: begin
                ctrl.reg_read = 2'b11;
                if (EN_M && funct7 == F7_M) begin
                    ctrl.md_en = 1'b1;
                    ctrl.md_op = funct3;
                end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    ctrl.alu_type = {2'b00, funct3} + ((funct7 == F7_ALT) ? 5'd8 : 5'd0);
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            default: ctrl.illegal = 1'b1;
        endcase
        // An illegal op must not produce any architectural side effect downstream.
        if (ctrl.illegal) begin
            ctrl.reg_write   = NOREGWRITE;
            ctrl.mem_write   = 4'b0000;
            ctrl.branch_type = NOBRANCH;
            ctrl.jal         = 1'b0;
            ctrl.jalr        = 1'b0;
            ctrl.md_en       = 1'b0;
        end
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode/control stage: valid/ready pipeline register, flush,
// and the MUL/DIV hold counter that stalls issue while EX iterates.
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter bit          EN_M       = 1'b1,
    parameter int unsigned MUL_CYCLES = 1,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned ALU_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             jal,
    output logic             jalr,
    output logic             load_npc,
    output logic             mem_to_reg,
    output logic             alu_src1,
    output logic [2:0]       reg_write,
    output logic [3:0]       mem_write,
    output logic [1:0]       reg_read,
    output logic [2:0]       branch_type,
    output logic [ALU_W-1:0] alu_type,
    output logic [1:0]       alu_src2,
    output logic [2:0]       imm_type,
    output logic             md_en,
    output logic [2:0]       md_op,
    output logic             illegal,
    output logic             md_busy
);

    localparam logic [7:0] DIV_HOLD = 8'(DIV_CYCLES - 1);
    localparam logic [7:0] MUL_HOLD = 8'(MUL_CYCLES - 1);

    ctrl_t      dec;
    ctrl_t      q;
    logic [31:0] pc_q;
    logic [7:0]  cnt;
    logic        accept;
    logic        out_fire;

    decode_ctrl_pipe_comb #(.EN_M(EN_M)) u_comb (
        .instr (in_instr),
        .ctrl  (dec)
    );

    assign in_ready = (~out_valid | out_ready) & (cnt == 8'd0) & ~flush;
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
            pc_q      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q         <= dec;
            pc_q      <= in_pc;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // The hold starts when EX takes the M op, not when decode accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (flush) begin
            cnt <= 8'd0;
        end else if (out_fire && q.md_en) begin
            cnt <= md_is_div(q.md_op) ? DIV_HOLD : MUL_HOLD;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign md_busy     = (cnt != 8'd0);
    assign out_pc      = pc_q;
    assign rs1         = q.rs1;
    assign rs2         = q.rs2;
    assign rd          = q.rd;
    assign jal         = q.jal;
    assign jalr        = q.jalr;
    assign load_npc    = q.load_npc;
    assign mem_to_reg  = q.mem_to_reg;
    assign alu_src1    = q.alu_src1;
    assign reg_write   = q.reg_write;
    assign mem_write   = q.mem_write;
    assign reg_read    = q.reg_read;
    assign branch_type = q.branch_type;
    assign alu_type    = ALU_W'(q.alu_type);
    assign alu_src2    = q.alu_src2;
    assign imm_type    = q.imm_type;
    assign md_en       = q.md_en;
    assign md_op       = q.md_op;
    assign illegal     = q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode vectors, handshake, stall,
// DIV hold, flush and reset, plus an EN_M=0 instance for M-op illegality.
module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid, jal, jalr, load_npc, mem_to_reg, alu_src1;
    logic        md_en, illegal, md_busy;
    logic [31:0] out_pc;
    logic [4:0]  rs1, rs2, rd, alu_type;
    logic [2:0]  reg_write, branch_type, imm_type, md_op;
    logic [3:0]  mem_write;
    logic [1:0]  reg_read, alu_src2;

    logic        n_in_ready, n_out_valid, n_jal, n_jalr, n_load_npc, n_mem_to_reg, n_alu_src1;
    logic        n_md_en, n_illegal, n_md_busy;
    logic [31:0] n_out_pc;
    logic [4:0]  n_rs1, n_rs2, n_rd, n_alu_type;
    logic [2:0]  n_reg_write, n_branch_type, n_imm_type, n_md_op;
    logic [3:0]  n_mem_write;
    logic [1:0]  n_reg_read, n_alu_src2;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.EN_M(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(32), .ALU_W(5)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .jal(jal), .jalr(jalr), .load_npc(load_npc), .mem_to_reg(mem_to_reg), .alu_src1(alu_src1),
        .reg_write(reg_write), .mem_write(mem_write), .reg_read(reg_read),
        .branch_type(branch_type), .alu_type(alu_type), .alu_src2(alu_src2), .imm_type(imm_type),
        .md_en(md_en), .md_op(md_op), .illegal(illegal), .md_busy(md_busy)
    );

    decode_ctrl_pipe #(.EN_M(1'b0), .MUL_CYCLES(1), .DIV_CYCLES(32), .ALU_W(5)) u_nom (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
        .rs1(n_rs1), .rs2(n_rs2), .rd(n_rd),
        .jal(n_jal), .jalr(n_jalr), .load_npc(n_load_npc), .mem_to_reg(n_mem_to_reg), .alu_src1(n_alu_src1),
        .reg_write(n_reg_write), .mem_write(n_mem_write), .reg_read(n_reg_read),
        .branch_type(n_branch_type), .alu_type(n_alu_type), .alu_src2(n_alu_src2), .imm_type(n_imm_type),
        .md_en(n_md_en), .md_op(n_md_op), .illegal(n_illegal), .md_busy(n_md_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        step; step;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_md_busy",   32'(md_busy),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_rd",        32'(rd),        32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_out_pc",    out_pc,         32'd0);
        rst = 1'b0;
        step;

        // addi x1,x0,5
        in_instr = 32'h00500093; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
        step;
        chk("addi_valid",     32'(out_valid), 32'd1);
        chk("addi_reg_write", 32'(reg_write), 32'd3);
        chk("addi_imm_type",  32'(imm_type),  32'd1);
        chk("addi_alu_src2",  32'(alu_src2),  32'b10);
        chk("addi_alu_type",  32'(alu_type),  32'd0);
        chk("addi_rd",        32'(rd),        32'd1);
        chk("addi_illegal",   32'(illegal),   32'd0);
        chk("addi_pc",        out_pc,         32'h100);

        // sb x2,0(x1)
        in_instr = 32'h00208023; in_pc = 32'h104;
        step;
        chk("sb_mem_write", 32'(mem_write), 32'b0001);
        chk("sb_reg_write", 32'(reg_write), 32'd0);
        chk("sb_reg_read",  32'(reg_read),  32'b11);
        chk("sb_imm_type",  32'(imm_type),  32'd2);
        chk("sb_pc",        out_pc,         32'h104);
        in_valid = 1'b0;
        step;
        chk("drain_valid", 32'(out_valid), 32'd0);

        // div x3,x1,x2
        in_instr = 32'h0220C1B3; in_pc = 32'h108; in_valid = 1'b1;
        step;
        chk("div_valid",     32'(out_valid), 32'd1);
        chk("div_md_en",     32'(md_en),     32'd1);
        chk("div_md_op",     32'(md_op),     32'b100);
        chk("div_rd",        32'(rd),        32'd3);
        chk("div_alu_type",  32'(alu_type),  32'd0);
        chk("div_busy_pre",  32'(md_busy),   32'd0);
        chk("nom_div_illegal",   32'(n_illegal),   32'd1);
        chk("nom_div_reg_write", 32'(n_reg_write), 32'd0);
        chk("nom_div_mem_write", 32'(n_mem_write), 32'd0);
        chk("nom_div_md_en",     32'(n_md_en),     32'd0);
        in_valid = 1'b0;
        step;
        n = 0;
        while (md_busy && n < 100) begin
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            n++;
            step;
        end
        chk("hold_cycles",   32'(n),        32'd31);
        chk("hold_released", 32'(in_ready), 32'd1);

        // stall: add x5,x6,x7 held while sub waits
        in_instr = 32'h007302B3; in_valid = 1'b1; out_ready = 1'b0;
        step;
        chk("add_rd", 32'(rd), 32'd5);
        in_instr = 32'h40730333;
        #1;
        chk("stall_in_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("stall_valid",    32'(out_valid), 32'd1);
            chk("stall_rd",       32'(rd),        32'd5);
            chk("stall_rs1",      32'(rs1),       32'd6);
            chk("stall_rs2",      32'(rs2),       32'd7);
            chk("stall_alu_type", 32'(alu_type),  32'd0);
            chk("stall_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        step;
        chk("sub_rd",       32'(rd),       32'd6);
        chk("sub_alu_type", 32'(alu_type), 32'd8);
        in_valid = 1'b0;
        step;
        chk("sub_drain", 32'(out_valid), 32'd0);

        // flush 5 cycles into a div hold
        in_instr = 32'h0220C1B3; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        repeat (4) step;
        chk("flush_busy_before", 32'(md_busy), 32'd1);
        flush = 1'b1; in_instr = 32'h00500093; in_valid = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_md_busy",   32'(md_busy),   32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        #1;
        chk("flush_in_ready_after", 32'(in_ready), 32'd1);

        // flush kills a held instruction
        in_instr = 32'h00500093; in_valid = 1'b1; out_ready = 1'b0;
        step;
        chk("kill_pre_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; flush = 1'b1;
        step;
        flush = 1'b0; out_ready = 1'b1;
        chk("kill_out_valid", 32'(out_valid), 32'd0);

        // assorted decode vectors
        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        step;
        chk("ff_illegal",   32'(illegal),     32'd1);
        chk("ff_reg_write", 32'(reg_write),   32'd0);
        chk("ff_mem_write", 32'(mem_write),   32'd0);
        chk("ff_branch",    32'(branch_type), 32'd0);
        in_instr = 32'h00002063;
        step;
        chk("br3_illegal", 32'(illegal),     32'd1);
        chk("br3_branch",  32'(branch_type), 32'd0);
        in_instr = 32'h00208063;
        step;
        chk("beq_branch",    32'(branch_type), 32'b110);
        chk("beq_reg_write", 32'(reg_write),   32'd0);
        chk("beq_imm_type",  32'(imm_type),    32'd3);
        in_instr = 32'h0000A203;
        step;
        chk("lw_reg_write",  32'(reg_write),  32'd3);
        chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        in_instr = 32'h0000C203;
        step;
        chk("lbu_reg_write", 32'(reg_write), 32'd5);
        in_instr = 32'h0000B203;
        step;
        chk("ld_illegal", 32'(illegal), 32'd1);
        in_instr = 32'h0020A023;
        step;
        chk("sw_mem_write", 32'(mem_write), 32'b1111);
        in_instr = 32'h0020B023;
        step;
        chk("sd_illegal",   32'(illegal),   32'd1);
        chk("sd_mem_write", 32'(mem_write), 32'd0);
        in_instr = 32'h000000EF;
        step;
        chk("jal_jal",      32'(jal),      32'd1);
        chk("jal_load_npc", 32'(load_npc), 32'd1);
        chk("jal_imm_type", 32'(imm_type), 32'd5);

        // reset in the middle of a div hold
        in_instr = 32'h0220C1B3;
        step;
        in_valid = 1'b0;
        step;
        chk("rst_hold_busy", 32'(md_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst2_md_busy",   32'(md_busy),   32'd0);
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_md_en",     32'(md_en),     32'd0);
        chk("rst2_rd",        32'(rd),        32'd0);
        chk("rst2_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
